// File: rtl/pc_watch_unit_if.sv
// rtl/pc_watch_unit_if.sv - core-side and debug-side signal bundle for pc_watch_unit
interface pc_watch_unit_if #(
  parameter int ADDR_W      = 32,
  parameter int NUM_WATCH   = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 16
);
  localparam int IDX_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
  localparam int TR_W  = $clog2(TRACE_DEPTH);

  logic [ADDR_W-1:0]    PC;
  logic                 PC_VALID;
  logic                 STALL;
  logic                 BRANCH_TAKEN;
  logic                 CFG_WE;
  logic [IDX_W-1:0]     CFG_IDX;
  logic [ADDR_W-1:0]    CFG_ADDR;
  logic                 CFG_EN;
  logic                 CLR;
  logic                 FREEZE;
  logic [NUM_WATCH-1:0] HIT;
  logic                 HIT_ANY;
  logic [IDX_W-1:0]     RD_IDX;
  logic [CNT_W-1:0]     RD_COUNT;
  logic [CNT_W-1:0]     STALL_CNT;
  logic [CNT_W-1:0]     BR_CNT;
  logic [TR_W-1:0]      TR_IDX;
  logic [ADDR_W-1:0]    TR_PC;
  logic [TR_W:0]        TR_COUNT;

  modport master (
    output PC, PC_VALID, STALL, BRANCH_TAKEN, CFG_WE, CFG_IDX, CFG_ADDR, CFG_EN,
           CLR, FREEZE, RD_IDX, TR_IDX,
    input  HIT, HIT_ANY, RD_COUNT, STALL_CNT, BR_CNT, TR_PC, TR_COUNT
  );

  modport slave (
    input  PC, PC_VALID, STALL, BRANCH_TAKEN, CFG_WE, CFG_IDX, CFG_ADDR, CFG_EN,
           CLR, FREEZE, RD_IDX, TR_IDX,
    output HIT, HIT_ANY, RD_COUNT, STALL_CNT, BR_CNT, TR_PC, TR_COUNT
  );
endinterface

// File: rtl/pc_watch_unit.sv
// rtl/pc_watch_unit.sv - PC watchpoints, saturating event counters and a circular trace of distinct PCs
module pc_watch_unit #(
  parameter int ADDR_W      = 32,
  parameter int NUM_WATCH   = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 16
) (
  input logic             CLK,
  input logic             RST,
  pc_watch_unit_if.slave  bus
);
  localparam int TR_W = $clog2(TRACE_DEPTH);
  localparam int TC_W = TR_W + 1;
  localparam logic [TC_W-1:0] DEPTH = TC_W'(TRACE_DEPTH);

  logic [ADDR_W-1:0]    addr [NUM_WATCH];
  logic [CNT_W-1:0]     cnt  [NUM_WATCH];
  logic [ADDR_W-1:0]    tbuf [TRACE_DEPTH];
  logic [NUM_WATCH-1:0] en;
  logic [NUM_WATCH-1:0] match;
  logic [NUM_WATCH-1:0] hit;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     br_cnt;
  logic [TR_W-1:0]      wptr;
  logic [TR_W-1:0]      rd_ptr;
  logic [TC_W-1:0]      tr_count;
  logic [ADDR_W-1:0]    last_pc;
  logic                 seen;
  logic                 ev;
  logic                 cfg_ok;
  logic                 rd_ok;
  logic                 tr_ok;

  // A PC held across stall cycles is one fetch, so only a change (or the first PC) counts.
  assign ev     = bus.PC_VALID && (!seen || (bus.PC != last_pc));
  assign cfg_ok = 32'(bus.CFG_IDX) < NUM_WATCH;
  assign rd_ok  = 32'(bus.RD_IDX) < NUM_WATCH;
  assign tr_ok  = {1'b0, bus.TR_IDX} < tr_count;
  assign rd_ptr = wptr - TR_W'(1) - bus.TR_IDX;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_WATCH; i++) begin
      match[i] = ev && en[i] && (bus.PC == addr[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        addr[i] <= '0;
        cnt[i]  <= '0;
      end
      en        <= '0;
      hit       <= '0;
      stall_cnt <= '0;
      br_cnt    <= '0;
      wptr      <= '0;
      tr_count  <= '0;
      last_pc   <= '0;
      seen      <= 1'b0;
    end else begin
      if (bus.CFG_WE && cfg_ok) begin
        addr[bus.CFG_IDX] <= bus.CFG_ADDR;
        en[bus.CFG_IDX]   <= bus.CFG_EN;
      end
      if (bus.CLR) begin
        for (int i = 0; i < NUM_WATCH; i++) begin
          cnt[i] <= '0;
        end
        hit       <= '0;
        stall_cnt <= '0;
        br_cnt    <= '0;
        wptr      <= '0;
        tr_count  <= '0;
        seen      <= 1'b0;
      end else begin
        hit <= match;
        for (int i = 0; i < NUM_WATCH; i++) begin
          if (match[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
        end
        if (bus.STALL && (stall_cnt != '1))     stall_cnt <= stall_cnt + 1'b1;
        if (bus.BRANCH_TAKEN && (br_cnt != '1)) br_cnt    <= br_cnt + 1'b1;
        if (ev) begin
          last_pc <= bus.PC;
          seen    <= 1'b1;
          // Freeze only stops recording; event detection keeps running underneath.
          if (!bus.FREEZE) begin
            tbuf[wptr] <= bus.PC;
            wptr       <= wptr + 1'b1;
            if (tr_count != DEPTH) tr_count <= tr_count + 1'b1;
          end
        end
      end
    end
  end

  assign bus.HIT       = hit;
  assign bus.HIT_ANY   = |hit;
  assign bus.RD_COUNT  = rd_ok ? cnt[bus.RD_IDX] : '0;
  assign bus.STALL_CNT = stall_cnt;
  assign bus.BR_CNT    = br_cnt;
  assign bus.TR_PC     = tr_ok ? tbuf[rd_ptr] : '0;
  assign bus.TR_COUNT  = tr_count;
endmodule

// File: doc/pc_watch_unit.md
Name: pc_watch_unit

Overview:
Synthesizable program-counter watchpoint and trace monitor that sits beside the OTTER core inside OTTER_Wrapper.
- Compares the core PC against NUM_WATCH runtime-programmable addresses (e.g. the Multi subroutine at 0x010C) and raises registered hit pulses.
- Keeps saturating per-watchpoint hit counts, stall and taken-branch event counters, and a circular trace of the last TRACE_DEPTH distinct PCs for on-board debug.

Parameters:
ADDR_W, 32, width of PC and watch addresses
NUM_WATCH, 4, number of watchpoint comparators (1..16)
TRACE_DEPTH, 16, trace buffer entries; power of two, >= 2
CNT_W, 16, width of all event counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, synchronous, active-high
PC  in  ADDR_W  current core PC
PC_VALID  in  1  PC is a real fetch this cycle
STALL  in  1  core load-use stall asserted
BRANCH_TAKEN  in  1  taken branch/jump this cycle
CFG_WE  in  1  write watchpoint config
CFG_IDX  in  clog2(NUM_WATCH) (min 1)  watchpoint written
CFG_ADDR  in  ADDR_W  watch address
CFG_EN  in  1  watchpoint enable
CLR  in  1  clear counters and trace (config kept)
FREEZE  in  1  suspend trace recording
HIT  out  NUM_WATCH  per-watchpoint one-cycle hit pulse
HIT_ANY  out  1  OR of HIT
RD_IDX  in  clog2(NUM_WATCH) (min 1)  hit-counter select
RD_COUNT  out  CNT_W  hit count of watchpoint RD_IDX (combinational)
STALL_CNT  out  CNT_W  stall cycles seen
BR_CNT  out  CNT_W  taken branches seen
TR_IDX  in  clog2(TRACE_DEPTH)  trace read index, 0 = most recent
TR_PC  out  ADDR_W  trace entry TR_IDX (combinational)
TR_COUNT  out  clog2(TRACE_DEPTH)+1  valid trace entries

Behaviour:
- Reset (RST=1 at a rising edge):
  - All watch addresses and enables, hit counters, STALL_CNT, BR_CNT, TR_COUNT, write pointer, last_pc and the seen flag clear to 0.
  - HIT=0 and HIT_ANY=0.
  - RST overrides every other input, including mid-operation.
- New-PC event (ev):
  - ev = PC_VALID && (!seen || PC != last_pc).
  - On ev: last_pc <= PC and seen <= 1.
  - A PC held across stall cycles produces exactly one event.
- Match:
  - match[i] = ev && en[i] && (PC == addr[i]), compared against config registered before this edge.
  - HIT[i] <= match[i]: one-cycle pulse, latency 1 cycle after the event edge.
  - Otherwise HIT is 0.
- Config:
  - CFG_WE writes addr[CFG_IDX] and en[CFG_IDX] at the edge.
  - A write in the same cycle as a matching event does not affect that event.
  - CFG_IDX >= NUM_WATCH: write ignored.
- Hit counters:
  - cnt[i] increments on match[i] and saturates at 2^CNT_W-1.
  - RD_IDX >= NUM_WATCH reads 0.
- STALL_CNT: +1 per cycle with STALL=1, saturating.
- BR_CNT: +1 per cycle with BRANCH_TAKEN=1, saturating.
- STALL and BRANCH_TAKEN are counted regardless of PC_VALID.
- Trace:
  - On ev && !FREEZE: buf[wptr] <= PC, wptr <= (wptr+1) mod TRACE_DEPTH, TR_COUNT <= min(TR_COUNT+1, TRACE_DEPTH).
  - Wrap-around overwrites the oldest entry.
  - TR_PC = buf[(wptr-1-TR_IDX) mod TRACE_DEPTH] when TR_IDX < TR_COUNT, else 0.
  - FREEZE does not stop ev tracking, matching or counting.
- CLR:
  - Synchronous. Clears hit counters, STALL_CNT, BR_CNT, TR_COUNT, wptr, seen and HIT.
  - Config is retained.
  - CLR coincident with an event or stall: the clear wins, and that cycle is not counted or recorded.
  - Buffer contents need not be zeroed; TR_COUNT=0 masks them.

Test Plan:
- Reset then idle: after RST held 3 cycles, all outputs 0; TR_PC=0 for every TR_IDX.
- Single watch:
  - Stimulus: cfg idx0 = 0x010C en=1; drive PC 0x0100,0x0104,0x0108,0x010C,0x0110 with PC_VALID=1.
  - Response: HIT=4'b0001 for exactly one cycle, the cycle after 0x010C is presented; RD_IDX=0 gives RD_COUNT=1.
- Stall hold: PC=0x010C held 5 cycles with STALL=1 -> one HIT pulse, RD_COUNT +1, STALL_CNT=5.
- Trace wrap (TRACE_DEPTH=16): 20 distinct PCs 0x00..0x4C, step 4 -> TR_COUNT=16, TR_IDX0=0x4C, TR_IDX15=0x10.
- FREEZE mid-stream:
  - Stimulus: FREEZE=1 after 3 PCs, then PC 0x010C with watch armed.
  - Response: TR_COUNT=3, HIT still pulses.
- Config write and clear collisions:
  - CFG_WE enabling 0x010C in the same cycle PC=0x010C arrives -> no HIT.
  - CLR coincident with BRANCH_TAKEN -> BR_CNT=0, config still matches next 0x010C.
  - Saturation with CNT_W=4 after 20 hits -> RD_COUNT=15.
